valid_delay_line: RTL



---
 rtl/valid_delay_line.sv | 82 ++++++++
 1 files changed

// File: rtl/valid_delay_line.sv
// Stallable, valid-tagged delay line used to match latencies between parallel arithmetic paths.
// Define DELAY_LINE_TAP_EN to add a runtime-selectable tap (tap_sel/tap_valid/tap_data).
module valid_delay_line #(
    parameter int WIDTH = 64,
    parameter int LANES = 1,
    parameter int DEPTH = 4,
    localparam int DW    = LANES * WIDTH,
    localparam int OCC_W = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1,
    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
`ifdef DELAY_LINE_TAP_EN
    input  logic [TAP_W-1:0] tap_sel,
    output logic             tap_valid,
    output logic [DW-1:0]    tap_data,
`endif
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic [OCC_W-1:0] occupancy
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("valid_delay_line: DEPTH must be at least 1");
    end
    if (WIDTH < 1 || LANES < 1) begin : g_bad_shape
        $error("valid_delay_line: WIDTH and LANES must be at least 1");
    end

    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0][DW-1:0] r_data;
    logic [OCC_W-1:0]         r_occ;

    // Occupancy is tracked incrementally so it never needs a popcount tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
            r_occ   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else if (en) begin
            r_valid[0] <= in_valid;
            r_data[0]  <= in_valid ? in_data : '0;
            for (int s = 1; s < DEPTH; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_data[s]  <= r_data[s-1];
            end
            r_occ <= r_occ + OCC_W'(in_valid) - OCC_W'(r_valid[DEPTH-1]);
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_valid[DEPTH-1] ? r_data[DEPTH-1] : '0;
    assign occupancy = r_occ;

`ifdef DELAY_LINE_TAP_EN
    logic          w_tap_valid;
    logic [DW-1:0] w_tap_data;

    // Out-of-range selects match no stage and therefore read as empty.
    always_comb begin
        w_tap_valid = 1'b0;
        w_tap_data  = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (int'(tap_sel) == s) begin
                w_tap_valid = r_valid[s];
                w_tap_data  = r_data[s];
            end
        end
    end

    assign tap_valid = w_tap_valid;
    assign tap_data  = w_tap_valid ? w_tap_data : '0;
`endif

endmodule
